compile_coordinator: RTL and testbench

COMPILE_COORDINATOR -- requirements
Module: compile_coordinator

---
 rtl/compile_coordinator.sv | 277 +++++++++++++++++++++++++++
 tb/tb_compile_coordinator.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compile_coordinator.sv
// -----------------------------------------------------------------------------
// compile_coordinator
//
// Coordinates an iterative-deepening search over sequence lengths. The host
// requests a search up to host_max_length. For each length 1..max the block
// pulses gen_start to an external sequence generator. It watches the stream
// of error results and tracks the lowest error seen, the length that produced
// it and its 0-based result ordinal. The search stops early once a result is
// at or below host_threshold. Results still in flight for that length are
// drained, up to the generator's gen_complete.
//
// Optional feature (macro COMPILE_COORDINATOR_TIMEOUT_EN):
//   A per-length watchdog. It is cleared in LAUNCH and counts every RUN/DRAIN
//   cycle. When it reaches TIMEOUT_CYCLES it sets host_timed_out and ends the
//   search, keeping the best_* values gathered so far. When the macro is not
//   defined there is no watchdog, host_timed_out is tied low, and RUN/DRAIN
//   wait for the generator indefinitely.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   host_start        single-cycle search request (honoured only in IDLE)
//   host_max_length   longest sequence length to try (0 = empty search)
//   host_threshold    acceptable error; error <= threshold ends the search
//   host_busy         high while not IDLE
//   host_done         single-cycle completion pulse
//   host_found        a result met the threshold
//   host_timed_out    search aborted by the watchdog
//   best_error        lowest error seen (all-ones when none)
//   best_length       length that produced best_error
//   best_seq_id       0-based result ordinal of best_error
//   gen_start         start pulse to the sequence generator
//   gen_max_length    length currently driven to the generator
//   gen_complete      generator finished the current length
//   result_valid      one error result is present this cycle
//   result_error      error value of that result
// -----------------------------------------------------------------------------
module compile_coordinator #(
    parameter int SEQ_INDEX_BITS = 5,
    parameter int ERROR_BITS     = 19,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      host_start,
    input  logic [SEQ_INDEX_BITS-1:0] host_max_length,
    input  logic [ERROR_BITS-1:0]     host_threshold,
    output logic                      host_busy,
    output logic                      host_done,
    output logic                      host_found,
    output logic                      host_timed_out,
    output logic [ERROR_BITS-1:0]     best_error,
    output logic [SEQ_INDEX_BITS-1:0] best_length,
    output logic [31:0]               best_seq_id,
    output logic                      gen_start,
    output logic [SEQ_INDEX_BITS-1:0] gen_max_length,
    input  logic                      gen_complete,
    input  logic                      result_valid,
    input  logic [ERROR_BITS-1:0]     result_error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        NEXT   = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [SEQ_INDEX_BITS-1:0] max_len_q, max_len_d;
    logic [SEQ_INDEX_BITS-1:0] cur_len_q, cur_len_d;
    logic [SEQ_INDEX_BITS-1:0] best_len_q, best_len_d;
    logic [ERROR_BITS-1:0]     thr_q, thr_d;
    logic [ERROR_BITS-1:0]     best_err_q, best_err_d;
    logic [31:0]               seq_id_q, seq_id_d;
    logic [31:0]               best_id_q, best_id_d;
    logic                      found_q, found_d;
    logic                      done_q, done_d;
    logic                      gen_start_q, gen_start_d;

    // Shared with the optional watchdog.
    logic                      clr_timeout;
    logic                      wd_expire;

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        max_len_d   = max_len_q;
        cur_len_d   = cur_len_q;
        best_len_d  = best_len_q;
        thr_d       = thr_q;
        best_err_d  = best_err_q;
        seq_id_d    = seq_id_q;
        best_id_d   = best_id_q;
        found_d     = found_q;
        done_d      = 1'b0;
        gen_start_d = 1'b0;
        clr_timeout = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (host_start) begin
                    clr_timeout = 1'b1;
                    found_d     = 1'b0;
                    if (host_max_length != '0) begin
                        max_len_d  = host_max_length;
                        thr_d      = host_threshold;
                        cur_len_d  = SEQ_INDEX_BITS'(1);
                        best_err_d = '1;
                        best_len_d = '0;
                        best_id_d  = '0;
                        seq_id_d   = '0;
                        state_d    = LAUNCH;
                    end else begin
                        // Empty search: answer immediately, best_* untouched.
                        done_d = 1'b1;
                    end
                end
            end

            LAUNCH: begin
                state_d = RUN;
            end

            RUN: begin
                if (result_valid) begin
                    seq_id_d = seq_id_q + 32'd1;
                    // Strictly-less keeps the earliest result on ties.
                    if (result_error < best_err_q) begin
                        best_err_d = result_error;
                        best_len_d = cur_len_q;
                        best_id_d  = seq_id_q;
                    end
                    if (result_error <= thr_q) begin
                        found_d = 1'b1;
                        state_d = gen_complete ? NEXT : DRAIN;
                    end else if (gen_complete) begin
                        state_d = NEXT;
                    end
                end else if (gen_complete) begin
                    state_d = NEXT;
                end
                if (wd_expire) begin
                    state_d = FINISH;
                end
            end

            DRAIN: begin
                // Late results from the current length are discarded.
                if (gen_complete) begin
                    state_d = NEXT;
                end
                if (wd_expire) begin
                    state_d = FINISH;
                end
            end

            NEXT: begin
                if (found_q || (cur_len_q == max_len_q)) begin
                    state_d = FINISH;
                end else begin
                    cur_len_d = cur_len_q + SEQ_INDEX_BITS'(1);
                    state_d   = LAUNCH;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Both pulses are registered so they coincide with the LAUNCH and
        // FINISH cycles respectively (or the cycle after an empty request).
        gen_start_d = (state_d == LAUNCH);
        done_d      = done_d | (state_d == FINISH);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            max_len_q   <= '0;
            cur_len_q   <= '0;
            best_len_q  <= '0;
            thr_q       <= '0;
            best_err_q  <= '1;
            seq_id_q    <= '0;
            best_id_q   <= '0;
            found_q     <= 1'b0;
            done_q      <= 1'b0;
            gen_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            max_len_q   <= max_len_d;
            cur_len_q   <= cur_len_d;
            best_len_q  <= best_len_d;
            thr_q       <= thr_d;
            best_err_q  <= best_err_d;
            seq_id_q    <= seq_id_d;
            best_id_q   <= best_id_d;
            found_q     <= found_d;
            done_q      <= done_d;
            gen_start_q <= gen_start_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional per-length watchdog
    // -------------------------------------------------------------------------
`ifdef COMPILE_COORDINATOR_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_BITS-1:0] wd_q, wd_d;
    logic               timed_out_q, timed_out_d;
    logic               wd_active;

    assign wd_active = (state_q == RUN) || (state_q == DRAIN);
    // This cycle is the TIMEOUT_CYCLES-th counted cycle of the length.
    assign wd_expire = wd_active && (wd_q == WD_BITS'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d        = wd_q;
        timed_out_d = timed_out_q;
        if (state_q == LAUNCH) begin
            wd_d = '0;
        end else if (wd_active) begin
            wd_d = wd_q + WD_BITS'(1);
        end
        if (clr_timeout) begin
            timed_out_d = 1'b0;
        end
        if (wd_expire) begin
            timed_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q        <= '0;
            timed_out_q <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign host_timed_out = timed_out_q;
`else
    logic unused_cfg;

    assign wd_expire      = 1'b0;
    assign host_timed_out = 1'b0;
    assign unused_cfg     = clr_timeout ^ (TIMEOUT_CYCLES != 0);
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign host_busy      = (state_q != IDLE);
    assign host_done      = done_q;
    assign host_found     = found_q;
    assign best_error     = best_err_q;
    assign best_length    = best_len_q;
    assign best_seq_id    = best_id_q;
    assign gen_start      = gen_start_q;
    assign gen_max_length = cur_len_q;

endmodule

// File: tb/tb_compile_coordinator.sv
// -----------------------------------------------------------------------------
// Testbench for compile_coordinator.
// A generator model replays a per-length plan of error results. A reference
// model walks the same plans in search order to predict the final best_*
// and found values. A compare process checks the held outputs every idle
// cycle.
// -----------------------------------------------------------------------------
module tb_compile_coordinator;

    localparam int SB   = 5;
    localparam int EB   = 19;
    localparam int ALL1 = (1 << EB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_start;
    logic [SB-1:0] host_max_length;
    logic [EB-1:0] host_threshold;
    logic          host_busy, host_done, host_found, host_timed_out;
    logic [EB-1:0] best_error;
    logic [SB-1:0] best_length;
    logic [31:0]   best_seq_id;
    logic          gen_start;
    logic [SB-1:0] gen_max_length;
    logic          gen_complete;
    logic          result_valid;
    logic [EB-1:0] result_error;

    always #5 clk = ~clk;

    compile_coordinator #(
        .SEQ_INDEX_BITS(SB),
        .ERROR_BITS    (EB),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .host_start     (host_start),
        .host_max_length(host_max_length),
        .host_threshold (host_threshold),
        .host_busy      (host_busy),
        .host_done      (host_done),
        .host_found     (host_found),
        .host_timed_out (host_timed_out),
        .best_error     (best_error),
        .best_length    (best_length),
        .best_seq_id    (best_seq_id),
        .gen_start      (gen_start),
        .gen_max_length (gen_max_length),
        .gen_complete   (gen_complete),
        .result_valid   (result_valid),
        .result_error   (result_error)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-length generator plans.
    int plan_n    [1:31];
    int plan_err  [1:31][4];
    int plan_gap  [1:31][4];
    bit plan_join [1:31];
    bit plan_hold [1:31];

    int started_q[$];
    int done_count = 0;
    int cyc = 0;
    int gs_cyc = 0;
    int done_cyc = 0;
    int noise_req = 0;
    int noise_done = 0;

    // Prediction for the search in flight, and the values the held outputs
    // must show while idle.
    int pend_err, pend_len, pend_id, pend_found, pend_to;
    int exp_err, exp_len, exp_id, exp_found, exp_to;

    task automatic clear_plans();
        for (int l = 1; l <= 31; l++) begin
            plan_n[l]    = 0;
            plan_join[l] = 1'b0;
            plan_hold[l] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                plan_err[l][k] = 0;
                plan_gap[l][k] = 0;
            end
        end
    endtask

    // Reference model: scan the results in the order the search visits them.
    task automatic model(input int maxl, input int thr, output int last_len);
        int  best, bl, bid, sid;
        bit  found, to;
        best = ALL1; bl = 0; bid = 0; sid = 0; found = 0; to = 0;
        last_len = 0;
        if (maxl == 0) begin
            pend_err = exp_err; pend_len = exp_len; pend_id = exp_id;
            pend_found = 0; pend_to = 0;
            return;
        end
        for (int l = 1; l <= maxl && !found && !to; l++) begin
            last_len = l;
            for (int k = 0; k < plan_n[l] && !found; k++) begin
                if (plan_err[l][k] < best) begin
                    best = plan_err[l][k]; bl = l; bid = sid;
                end
                sid++;
                if (plan_err[l][k] <= thr) found = 1;
            end
            if (plan_hold[l]) to = 1;
        end
        pend_err = best; pend_len = bl; pend_id = bid;
        pend_found = found; pend_to = to;
    endtask

    // Generator model.
    initial begin
        int l;
        result_valid = 1'b0;
        result_error = '0;
        gen_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_start === 1'b1) begin
                l = int'(gen_max_length);
                started_q.push_back(l);
                @(posedge clk); #1;
                for (int k = 0; k < plan_n[l]; k++) begin
                    repeat (plan_gap[l][k]) begin @(posedge clk); #1; end
                    result_valid = 1'b1;
                    result_error = EB'(plan_err[l][k]);
                    gen_complete = plan_join[l] && (k == plan_n[l] - 1);
                    @(posedge clk); #1;
                    result_valid = 1'b0;
                    gen_complete = 1'b0;
                end
                if (!plan_hold[l] && !(plan_join[l] && plan_n[l] > 0)) begin
                    gen_complete = 1'b1;
                    @(posedge clk); #1;
                    gen_complete = 1'b0;
                end
            end else if (noise_req != noise_done) begin
                // Stray generator activity while the block is idle.
                @(posedge clk); #1;
                result_valid = 1'b1;
                result_error = '0;
                gen_complete = 1'b1;
                @(posedge clk); #1;
                result_valid = 1'b0;
                gen_complete = 1'b0;
                noise_done++;
            end
        end
    end

    // Compare process: held outputs must match the model whenever idle.
    initial begin
        exp_err = ALL1; exp_len = 0; exp_id = 0; exp_found = 0; exp_to = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                exp_err = ALL1; exp_len = 0; exp_id = 0; exp_found = 0; exp_to = 0;
            end else begin
                if (gen_start === 1'b1) gs_cyc = cyc;
                if (host_done === 1'b1) begin
                    done_count++;
                    done_cyc = cyc;
                    exp_err = pend_err; exp_len = pend_len; exp_id = pend_id;
                    exp_found = pend_found; exp_to = pend_to;
                end
                if (host_busy !== 1'b1) begin
                    check("idle best_error", 64'(best_error), 64'(exp_err));
                    check("idle best_length", 64'(best_length), 64'(exp_len));
                    check("idle best_seq_id", 64'(best_seq_id), 64'(exp_id));
                    check("idle host_found", 64'(host_found), 64'(exp_found));
                    check("idle host_timed_out", 64'(host_timed_out), 64'(exp_to));
                    check("idle gen_start", 64'(gen_start), 64'd0);
                end
            end
        end
    end

    // Issue one search and check its completion.
    task automatic run_search(input int maxl, input int thr, input bit poke, input string tag);
        int last, d0, waited;
        model(maxl, thr, last);
        started_q.delete();
        d0 = done_count;
        @(posedge clk); #1;
        host_max_length = SB'(maxl);
        host_threshold  = EB'(thr);
        host_start      = 1'b1;
        @(posedge clk); #1;
        host_start = 1'b0;
        waited = 0;
        if (poke && maxl != 0) begin
            // Busy now; this request must be ignored.
            @(posedge clk); #1;
            host_start      = 1'b1;
            host_max_length = SB'(7);
            host_threshold  = EB'(ALL1);
            @(posedge clk); #1;
            host_start = 1'b0;
            waited = 2;
        end
        while (done_count == d0 && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        check({tag, " done seen"}, 64'(done_count != d0), 64'd1);
        if (maxl == 0) check({tag, " done latency"}, 64'(waited), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check({tag, " single done"}, 64'(done_count - d0), 64'd1);
        check({tag, " gen_start count"}, 64'(started_q.size()), 64'(last));
        for (int i = 0; i < started_q.size() && i < last; i++)
            check({tag, " gen length"}, 64'(started_q[i]), 64'(i + 1));
        check({tag, " busy after"}, 64'(host_busy), 64'd0);
        $display("[TB] %s max=%0d thr=%0d -> err=%0d len=%0d id=%0d found=%0d to=%0d",
                 tag, maxl, thr, best_error, best_length, best_seq_id, host_found, host_timed_out);
    endtask

    initial begin
        int d0, maxl, thr;
        reset = 1'b1;
        host_start = 1'b0;
        host_max_length = '0;
        host_threshold = '0;
        clear_plans();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #4;
        check("reset busy", 64'(host_busy), 64'd0);
        check("reset best_error", 64'(best_error), 64'(ALL1));
        check("reset done", 64'(host_done), 64'd0);
        check("reset gen_start", 64'(gen_start), 64'd0);
        check("reset gen_max_length", 64'(gen_max_length), 64'd0);

        // Full sweep, no threshold hit.
        clear_plans();
        plan_n[1] = 2; plan_err[1][0] = 50; plan_err[1][1] = 40;
        plan_n[2] = 2; plan_err[2][0] = 40; plan_err[2][1] = 30; plan_gap[2][1] = 1;
        plan_n[3] = 1; plan_err[3][0] = 35;
        run_search(3, 0, 1'b1, "sweep");
        check("sweep model err", 64'(pend_err), 64'd30);
        check("sweep best_error", 64'(best_error), 64'd30);
        check("sweep best_length", 64'(best_length), 64'd2);
        check("sweep best_seq_id", 64'(best_seq_id), 64'd3);
        check("sweep found", 64'(host_found), 64'd0);

        // Early hit at length 2, later results ignored, no length 3.
        clear_plans();
        plan_n[1] = 1; plan_err[1][0] = 20;
        plan_n[2] = 4; plan_err[2][0] = 15; plan_err[2][1] = 7;
        plan_err[2][2] = 3; plan_err[2][3] = 1; plan_gap[2][3] = 2;
        run_search(4, 10, 1'b0, "early");
        check("early model id", 64'(pend_id), 64'd2);
        check("early best_error", 64'(best_error), 64'd7);
        check("early best_seq_id", 64'(best_seq_id), 64'd2);
        check("early found", 64'(host_found), 64'd1);
        check("early starts", 64'(started_q.size()), 64'd2);

        // Hit coincides with gen_complete.
        clear_plans();
        plan_n[1] = 1; plan_err[1][0] = 9;
        plan_n[2] = 1; plan_err[2][0] = 5; plan_join[2] = 1'b1;
        run_search(3, 5, 1'b0, "joined");
        check("joined best_error", 64'(best_error), 64'd5);
        check("joined best_length", 64'(best_length), 64'd2);
        check("joined best_seq_id", 64'(best_seq_id), 64'd1);
        check("joined found", 64'(host_found), 64'd1);

        // Empty search, preceded by stray generator activity in IDLE.
        noise_req++;
        repeat (4) @(posedge clk);
        run_search(0, 0, 1'b0, "empty");
        check("empty found", 64'(host_found), 64'd0);
        check("empty best kept", 64'(best_error), 64'd5);

        // Reset in the middle of RUN.
        clear_plans();
        plan_n[1] = 3; plan_err[1][0] = 100; plan_err[1][1] = 90; plan_err[1][2] = 80;
        plan_gap[1][0] = 2; plan_gap[1][1] = 2; plan_gap[1][2] = 2;
        d0 = done_count;
        @(posedge clk); #1;
        host_max_length = SB'(3); host_threshold = '0; host_start = 1'b1;
        @(posedge clk); #1;
        host_start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("midreset no done", 64'(done_count - d0), 64'd0);
        check("midreset busy", 64'(host_busy), 64'd0);
        check("midreset best_error", 64'(best_error), 64'(ALL1));
        check("midreset found", 64'(host_found), 64'd0);
        $display("[TB] midreset -> busy=%0d err=%0d", host_busy, best_error);

`ifdef COMPILE_COORDINATOR_TIMEOUT_EN
        // Generator never completes length 1.
        clear_plans();
        plan_hold[1] = 1'b1;
        run_search(2, 0, 1'b0, "timeout");
        check("timeout flag", 64'(host_timed_out), 64'd1);
        check("timeout latency", 64'((done_cyc - gs_cyc) >= 17 && (done_cyc - gs_cyc) <= 18), 64'd1);
`endif

        // Randomized searches.
        for (int t = 0; t < 30; t++) begin
            clear_plans();
            maxl = (t % 10 == 9) ? 0 : int'($urandom_range(1, 6));
            thr  = int'($urandom_range(0, 40));
            for (int l = 1; l <= 6; l++) begin
                plan_n[l]    = int'($urandom_range(0, 3));
                plan_join[l] = $urandom_range(0, 1) == 1;
                for (int k = 0; k < 4; k++) begin
                    plan_err[l][k] = int'($urandom_range(0, 300));
                    plan_gap[l][k] = int'($urandom_range(0, 2));
                end
            end
            run_search(maxl, thr, $urandom_range(0, 1) == 1, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
